// File: rtl/uart_word_loader.sv
// uart_word_loader: framed length/payload/checksum program loader that holds the CPU in reset until a clean load
module uart_word_loader #(
  parameter int DBIT = 32,
  parameter int ADDR_W = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [DBIT-1:0]   rx_dout,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DBIT-1:0]   mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);
  localparam logic [DBIT:0] MAX_WORDS = (DBIT+1)'(2**ADDR_W - BASE_ADDR);
  typedef enum logic [2:0] {S_LEN, S_DATA, S_SUM, S_DONE, S_ERR} state_t;
  state_t state, state_n;
  logic [DBIT-1:0] len_reg, len_n, sum, sum_n, wdata_n;
  logic [ADDR_W:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic we_n;
  always_comb begin
    state_n = state;
    len_n = len_reg;
    cnt_n = cnt;
    sum_n = sum;
    we_n = 1'b0;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    case (state)
      S_LEN: if (rx_dout == '0 || {1'b0, rx_dout} > MAX_WORDS) begin
        state_n = rx_done_tick ? S_ERR : state;
      end else if (rx_done_tick) begin
        len_n = rx_dout;
        cnt_n = '0;
        sum_n = '0;
        state_n = S_DATA;
      end
      S_DATA: if (rx_done_tick) begin
        we_n = 1'b1;
        addr_n = ADDR_W'(BASE_ADDR) + cnt[ADDR_W-1:0];
        wdata_n = rx_dout;
        sum_n = sum + rx_dout;
        cnt_n = cnt + 1'b1;
        state_n = (DBIT'(cnt) == len_reg - DBIT'(1)) ? S_SUM : state;
      end
      S_SUM: state_n = rx_done_tick ? ((rx_dout == sum) ? S_DONE : S_ERR) : state;
      default: if (restart) begin
        state_n = S_LEN;
        cnt_n = '0;
        sum_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LEN;
      len_reg <= '0;
      cnt <= '0;
      sum <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cpu_hold <= 1'b1;
      busy <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_n;
      len_reg <= len_n;
      cnt <= cnt_n;
      sum <= sum_n;
      mem_we <= we_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      cpu_hold <= state_n != S_DONE;
      busy <= state_n == S_DATA || state_n == S_SUM;
      load_done <= state_n == S_DONE;
      load_err <= state_n == S_ERR;
    end
  end
endmodule
